multiword_add_seq: RTL and testbench

- Sequencer that performs wide add/subtract by time-multiplexing one SLICE_W-bit ripple-carry adder slice.
- Operands are processed one slice per cycle, least significant slice first, with the carry chained through a register.
- Sits between a requester using a valid/ready handshake and the shared narrow adder datapath. It trades latency for area compared with a full-width adder.

---
 rtl/multiword_add_seq_pkg.sv | 19 +
 rtl/multiword_add_seq_adder_slice.sv | 25 ++
 rtl/multiword_add_seq.sv | 114 +++++++++++
 tb/tb_multiword_add_seq.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/multiword_add_seq_pkg.sv
// Shared definitions for the slice-serial wide adder: default slice width,
// sequencer state encoding and the slice-counter width helper.
package multiword_add_seq_pkg;

  localparam int SLICE_W_DEFAULT    = 5;
  localparam int NUM_SLICES_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must index NUM_SLICES slices; a single-slice build still needs one bit.
  function automatic int cnt_width(input int num_slices);
    return (num_slices <= 1) ? 1 : $clog2(num_slices);
  endfunction

endpackage

// File: rtl/multiword_add_seq_adder_slice.sv
// Combinational SLICE_W-bit ripple-carry adder built from full-adder cells.
module adder_slice #(
  parameter int SLICE_W = multiword_add_seq_pkg::SLICE_W_DEFAULT
) (
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  always_comb begin
    // NOTE: blocking assignments here model the carry rippling bit to bit
    // inside one combinational evaluation; the local variable is a wire chain.
    logic carry;
    carry = ci;
    s     = '0;
    for (int i = 0; i < SLICE_W; i++) begin
      s[i]  = x[i] ^ y[i] ^ carry;
      carry = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/multiword_add_seq.sv
// Wide add/subtract sequencer: reuses one adder slice, LS slice first, with the
// inter-slice carry held in a register so the result matches a full-width adder.
module multiword_add_seq
  import multiword_add_seq_pkg::*;
#(
  parameter int SLICE_W    = SLICE_W_DEFAULT,
  parameter int NUM_SLICES = NUM_SLICES_DEFAULT,
  localparam int W         = SLICE_W * NUM_SLICES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         c_out
);

  localparam int CNT_W = cnt_width(NUM_SLICES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

  state_e             state_q, state_d;
  logic [W-1:0]       op_a_q, op_b_q, sum_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q, c_out_q;

  logic [SLICE_W-1:0] slice_x, slice_y, slice_s;
  logic               slice_co;
  logic               accept, last_slice;

  assign accept     = in_valid & in_ready;
  assign last_slice = (cnt_q == LAST_CNT);
  assign slice_x    = op_a_q[cnt_q * SLICE_W +: SLICE_W];
  assign slice_y    = op_b_q[cnt_q * SLICE_W +: SLICE_W];

  adder_slice #(.SLICE_W(SLICE_W)) u_slice (
    .x  (slice_x),
    .y  (slice_y),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all registered state, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last_slice) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: operand and result registers are reset too, so an aborted
      // operation leaves no stale data visible on sum after reset.
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            op_a_q  <= a;
            op_b_q  <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : c_in;
            cnt_q   <= '0;
            sum_q   <= '0;
          end
        end
        RUN: begin
          sum_q[cnt_q * SLICE_W +: SLICE_W] <= slice_s;
          carry_q <= slice_co;
          // Holding the counter on the last slice keeps it from wrapping.
          if (last_slice) c_out_q <= slice_co;
          else            cnt_q   <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed self-checking bench for multiword_add_seq (SLICE_W=5, NUM_SLICES=4).
module tb_multiword_add_seq;

  localparam int W = 20;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out;
  logic [W-1:0] a, b, sum;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multiword_add_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation, check partial low slice, latency, result and release.
  task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ci, input logic sb,
                       input logic [W-1:0] exp_sum, input logic exp_co);
    int n;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = av; b = bv; c_in = ci; sub = sb; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_busy"}, 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
      if (n == 1) check({tag, "_partial"}, 32'(sum), 32'(exp_sum & 20'h0001F));
    end
    check({tag, "_latency"}, n, 4);
    check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check({tag, "_c_out"}, 32'(c_out), 32'(exp_co));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;

    // Reset then idle
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_c_out", 32'(c_out), 32'd0);
    rst = 1'b0;
    a = 20'hFFFFF; b = 20'hFFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_hold_ready", 32'(in_ready), 32'd1);
      check("idle_hold_sum", 32'(sum), 32'd0);
    end

    // Arithmetic vectors
    do_op("add_basic", 20'h12345, 20'h0ABCD, 1'b0, 1'b0, 20'h1CF12, 1'b0);
    do_op("ripple_b1", 20'hFFFFF, 20'h00001, 1'b0, 1'b0, 20'h00000, 1'b1);
    do_op("ripple_cin", 20'hFFFFF, 20'h00000, 1'b1, 1'b0, 20'h00000, 1'b1);
    do_op("sub_borrow", 20'h00005, 20'h00007, 1'b1, 1'b1, 20'hFFFFE, 1'b0);
    do_op("sub_noborrow", 20'h00007, 20'h00005, 1'b0, 1'b1, 20'h00002, 1'b1);

    // Handshake: operand change mid-RUN, backpressure, ignored in_valid
    a = 20'h54321; b = 20'h11111; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    a = 20'hAAAAA; b = 20'h55555; c_in = 1'b1; sub = 1'b1;
    n = 1;
    while (!out_valid && n < 20) begin tick(); n++; end
    check("hs_latency", n, 4);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      tick();
      check("hs_hold_valid", 32'(out_valid), 32'd1);
      check("hs_hold_sum", 32'(sum), 32'h65432);
      check("hs_hold_c_out", 32'(c_out), 32'd0);
      check("hs_hold_ready", 32'(in_ready), 32'd0);
    end
    // in_valid high together with out_ready: must not be accepted from DONE
    a = 20'h00003; b = 20'h00004; c_in = 1'b0; sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hs_release_ready", 32'(in_ready), 32'd1);
    check("hs_release_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    check("hs_accept_busy", 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check("hs_next_latency", n, 4);
    check("hs_next_sum", 32'(sum), 32'h00007);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Make c_out nonzero before the abort so its reset is observable
    do_op("pre_abort", 20'hFFFFF, 20'h00002, 1'b0, 1'b0, 20'h00001, 1'b1);

    // Reset mid-RUN
    a = 20'h0F0F0; b = 20'h0F0F0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_c_out", 32'(c_out), 32'd0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) n++;
    end
    check("abort_no_spurious", n, 0);
    do_op("after_abort", 20'h0F0F0, 20'h0F0F0, 1'b0, 1'b0, 20'h1E1E0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
